// File: rtl/alien_line_scheduler_pkg.sv
// Shared types and constants for the alien line scheduler and its renderers.
package alien_line_scheduler_pkg;

   // Largest sprite half-height; an alien's half-height is SPRITE_HALF_MAX - _r.
   localparam int SPRITE_HALF_MAX = 32;

   // One alien table word.
   typedef struct packed {
      logic [9:0] x_pos;
      logic [9:0] y_pos;
      logic [4:0] _r;
      logic [2:0] sprite;
   } AlienData;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      CHECK,
      DONE
   } sched_state_t;

endpackage

// File: rtl/alien_line_scheduler_if.sv
// Table/control/publish bundle between the line timing, alien table and scheduler.
interface alien_line_scheduler_if
   import alien_line_scheduler_pkg::*;
#(
   parameter int MAX_ALIENS = 8,
   parameter int SLOTS      = 4
);
   logic                          line_start;
   logic [9:0]                    next_v;
   logic [$clog2(MAX_ALIENS):0]   alien_count;
   logic [$clog2(MAX_ALIENS)-1:0] tbl_addr;
   AlienData                      tbl_data;
   AlienData [SLOTS-1:0]          slot_data;
   logic [SLOTS-1:0]              slot_valid;
   logic                          overflow;
   logic                          late;

   modport master (
      output line_start, next_v, alien_count, tbl_data,
      input  tbl_addr, slot_data, slot_valid, overflow, late
   );

   modport slave (
      input  line_start, next_v, alien_count, tbl_data,
      output tbl_addr, slot_data, slot_valid, overflow, late
   );
endinterface

// File: rtl/alien_line_scheduler_match.sv
// Vertical span test: does alien d cover scanline v?
// Window is [y_pos - hh, y_pos + hh) with hh = SPRITE_HALF_MAX - _r, done in
// 12-bit signed so aliens near the top edge do not wrap.
module alien_line_match
   import alien_line_scheduler_pkg::*;
(
   input  AlienData   d,
   input  logic [9:0] v,
   output logic       hit
);
   logic signed [11:0] y_s;
   logic signed [11:0] hh_s;
   logic signed [11:0] v_s;

   assign y_s  = $signed({2'b00, d.y_pos});
   assign hh_s = $signed(12'(SPRITE_HALF_MAX)) - $signed({7'b0, d._r});
   assign v_s  = $signed({2'b00, v});
   assign hit  = ((y_s - hh_s) <= v_s) && (v_s < (y_s + hh_s));

   // Horizontal position and sprite index do not affect the vertical test.
   logic unused_ok;
   assign unused_ok = &{1'b0, d.x_pos, d.sprite};
endmodule

// File: rtl/alien_line_scheduler.sv
// Alien line scheduler: during each line, scans the alien table for the next
// scanline into a shadow list; line_start publishes that list to the renderer
// slots and restarts the scan.
// Build option ALIEN_SCHED_DEPTH_SORT_EN: keep the shadow list in ascending _r
// (nearest first), evicting the farthest entry when a nearer alien arrives.
module alien_line_scheduler
   import alien_line_scheduler_pkg::*;
#(
   parameter int MAX_ALIENS = 8,
   parameter int SLOTS      = 4
)
(
   input logic                   clk,
   input logic                   rst_n,
   alien_line_scheduler_if.slave bus
);
   localparam int AW = $clog2(MAX_ALIENS);
   localparam int CW = AW + 1;
   localparam int SW = $clog2(SLOTS + 1);

   sched_state_t         state;
   logic [AW-1:0]        idx;
   logic [CW-1:0]        cnt_q;
   logic [9:0]           v_q;
   AlienData [SLOTS-1:0] sh_data;
   logic [SW-1:0]        sh_cnt;
   logic                 sh_ovf;

   AlienData [SLOTS-1:0] sh_up;
   AlienData [SLOTS-1:0] ins_list;
   logic [SW-1:0]        ins_pos;
   logic [SLOTS-1:0]     sh_valid;
   logic                 sh_full;
   logic                 accept;
   logic                 hit;
   logic [CW-1:0]        idx_inc;
   logic [CW-1:0]        cnt_clamp;

   alien_line_match u_match (
      .d   (bus.tbl_data),
      .v   (v_q),
      .hit (hit)
   );

   assign idx_inc   = {1'b0, idx} + 1'b1;
   // Counts beyond the table size would index past the end; scan the whole table instead.
   assign cnt_clamp = (bus.alien_count > CW'(MAX_ALIENS)) ? CW'(MAX_ALIENS) : bus.alien_count;

   // Insert position for the word under test and the resulting shadow list.
   always_comb begin
      sh_up   = sh_data << $bits(AlienData);
      sh_full = (sh_cnt == SW'(SLOTS));
`ifdef ALIEN_SCHED_DEPTH_SORT_EN
      // List is sorted, so entries with _r <= new _r form a prefix; equal _r stays in table order.
      ins_pos = '0;
      for (int i = 0; i < SLOTS; i++)
         if ((SW'(i) < sh_cnt) && (sh_data[i]._r <= bus.tbl_data._r))
            ins_pos = ins_pos + 1'b1;
`else
      ins_pos = sh_cnt;
`endif
      for (int i = 0; i < SLOTS; i++) begin
         if (SW'(i) < ins_pos)       ins_list[i] = sh_data[i];
         else if (SW'(i) == ins_pos) ins_list[i] = bus.tbl_data;
         else                        ins_list[i] = sh_up[i];
         sh_valid[i] = (SW'(i) < sh_cnt);
      end
      // When full, only a word landing inside the list (pushing the farthest out) is kept.
      accept = !sh_full || (ins_pos < SW'(SLOTS));
   end

   // Scan FSM, shadow list and published outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= IDLE;
         idx            <= '0;
         cnt_q          <= '0;
         v_q            <= '0;
         sh_data        <= '0;
         sh_cnt         <= '0;
         sh_ovf         <= 1'b0;
         bus.tbl_addr   <= '0;
         bus.slot_data  <= '0;
         bus.slot_valid <= '0;
         bus.overflow   <= 1'b0;
         bus.late       <= 1'b0;
      end else if (bus.line_start) begin
         bus.slot_data  <= sh_data;
         bus.slot_valid <= sh_valid;
         bus.overflow   <= sh_ovf;
         bus.late       <= (state == FETCH) || (state == CHECK);
         sh_data        <= '0;
         sh_cnt         <= '0;
         sh_ovf         <= 1'b0;
         idx            <= '0;
         bus.tbl_addr   <= '0;
         v_q            <= bus.next_v;
         cnt_q          <= cnt_clamp;
         state          <= (cnt_clamp == '0) ? DONE : FETCH;
      end else begin
         case (state)
            FETCH: state <= CHECK;
            CHECK: begin
               if (hit) begin
                  if (accept) begin
                     sh_data <= ins_list;
                     if (!sh_full) sh_cnt <= sh_cnt + 1'b1;
                  end
                  if (sh_full) sh_ovf <= 1'b1;
               end
               idx <= idx_inc[AW-1:0];
               if (idx_inc < cnt_q) begin
                  bus.tbl_addr <= idx_inc[AW-1:0];
                  state        <= FETCH;
               end else begin
                  state <= DONE;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_alien_line_scheduler.sv
// Bench for alien_line_scheduler: directed scenarios against a list-level model
// (match rule + stable sort + cycle-count scan progress), checked every cycle.
module tb_alien_line_scheduler;
   import alien_line_scheduler_pkg::*;

   localparam int MAX_ALIENS = 8;
   localparam int SLOTS      = 4;
   localparam int CW         = $clog2(MAX_ALIENS) + 1;

   typedef struct {
      logic [SLOTS-1:0]     valid;
      AlienData [SLOTS-1:0] data;
      logic                 ovf;
      logic                 late;
   } pub_t;

   logic clk = 1'b0;
   logic rst_n;
   bit   armed = 1'b0;
   int   n_checks = 0;
   int   n_pass = 0;

   AlienData tbl  [MAX_ALIENS];
   AlienData snap [MAX_ALIENS];
   pub_t     expv;
   int       cyc = 0;
   int       ts = 0;
   int       sv = 0;
   int       sc = 0;
   bit       started = 1'b0;

   alien_line_scheduler_if #(.MAX_ALIENS(MAX_ALIENS), .SLOTS(SLOTS)) bus ();

   alien_line_scheduler #(.MAX_ALIENS(MAX_ALIENS), .SLOTS(SLOTS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   // Synchronous table RAM: word valid one cycle after the address.
   always @(posedge clk) bus.tbl_data <= tbl[bus.tbl_addr];

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %0h want %0h", name, got, want);
   endtask

   function automatic AlienData mk(input int i, input int y, input int r);
      AlienData a;
      a.x_pos  = 10'(i * 20 + 3);
      a.y_pos  = 10'(y);
      a._r     = 5'(r);
      a.sprite = 3'(i);
      return a;
   endfunction

   // What a line_start publishes: entries fully checked in d cycles, matched, optionally sorted.
   function automatic pub_t model_publish(input AlienData s[MAX_ALIENS], input int v, input int c,
                                          input bit st, input int d);
      AlienData m[$];
      AlienData t;
      pub_t     p;
      int       n, y, hh;
      p.valid = '0;
      p.data  = '0;
      p.ovf   = 1'b0;
      p.late  = 1'b0;
      n = 0;
      if (st) begin
         n = (d - 1) / 2;
         if (n > c) n = c;
         p.late = (c > 0) && (d <= 2 * c);
      end
      for (int k = 0; k < n; k++) begin
         y  = int'(s[k].y_pos);
         hh = SPRITE_HALF_MAX - int'(s[k]._r);
         if (v >= y - hh && v < y + hh) m.push_back(s[k]);
      end
`ifdef ALIEN_SCHED_DEPTH_SORT_EN
      for (int i = 0; i < m.size(); i++)
         for (int j = m.size() - 1; j > i; j--)
            if (m[j-1]._r > m[j]._r) begin
               t = m[j]; m[j] = m[j-1]; m[j-1] = t;
            end
`endif
      p.ovf = (m.size() > SLOTS);
      for (int i = 0; i < SLOTS; i++)
         if (i < m.size()) begin
            p.valid[i] = 1'b1;
            p.data[i]  = m[i];
         end
      return p;
   endfunction

   // Address on the bus e edges after scan start: one new entry every two cycles.
   function automatic int model_addr(input bit st, input int c, input int e);
      if (!st || c == 0) return 0;
      return (e / 2 < c - 1) ? e / 2 : c - 1;
   endfunction

   // Model state update on each rising edge.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!rst_n) begin
         expv    <= '{'0, '0, 1'b0, 1'b0};
         started <= 1'b0;
         sc      <= 0;
         ts      <= cyc;
      end else if (bus.line_start) begin
         expv    <= model_publish(snap, sv, sc, started, cyc - ts);
         snap    <= tbl;
         sv      <= int'(bus.next_v);
         sc      <= (int'(bus.alien_count) > MAX_ALIENS) ? MAX_ALIENS : int'(bus.alien_count);
         ts      <= cyc;
         started <= 1'b1;
      end
   end

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      if (armed) begin
         check("slot_valid", 128'(bus.slot_valid), 128'(expv.valid));
         check("slot_data",  128'(bus.slot_data),  128'(expv.data));
         check("overflow",   128'(bus.overflow),   128'(expv.ovf));
         check("late",       128'(bus.late),       128'(expv.late));
         check("tbl_addr",   128'(bus.tbl_addr),   128'(model_addr(started, sc, cyc - 1 - ts)));
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse(input int v, input int c);
      bus.line_start  = 1'b1;
      bus.next_v      = 10'(v);
      bus.alien_count = CW'(c);
      @(negedge clk);
      bus.line_start  = 1'b0;
   endtask

   // Boundary vectors for the match window: y, r, v, expected hit.
   int hy [6] = '{10, 10, 10, 50, 50, 5};
   int hr [6] = '{ 0,  0,  0, 30, 30, 31};
   int hv [6] = '{ 0, 42, 41, 48, 47, 3};
   int he [6] = '{ 1,  0,  1,  1,  0, 0};

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      rst_n           = 1'b0;
      bus.line_start  = 1'b0;
      bus.next_v      = '0;
      bus.alien_count = '0;
      for (int i = 0; i < MAX_ALIENS; i++) tbl[i] = mk(i, 0, 0);
      tick(2);
      armed = 1'b1;
      check("rst_valid", 128'(bus.slot_valid), 128'(0));
      check("rst_addr",  128'(bus.tbl_addr),   128'(0));
      rst_n = 1'b1;
      tick(1);

      // Three aliens, only entry 0 spans line 80; full scan then publish.
      tbl[0] = mk(0, 100, 0);
      tbl[1] = mk(1, 300, 16);
      tbl[2] = mk(2, 50, 30);
      pulse(80, 3);
      tick(6);
      pulse(0, 0);
      check("A_valid", 128'(bus.slot_valid),      128'(4'b0001));
      check("A_y0",    128'(bus.slot_data[0].y_pos), 128'(100));
      check("A_late",  128'(bus.late),            128'(0));

      // Match window boundaries, one alien per scan.
      for (int i = 0; i < 6; i++) begin
         tbl[0] = mk(0, hy[i], hr[i]);
         pulse(hv[i], 1);
         tick(3);
         pulse(0, 0);
         check("hit_vec", 128'(bus.slot_valid), 128'(he[i]));
      end

      // Six matching aliens into four slots.
      for (int i = 0; i < 6; i++) tbl[i] = mk(i, 100, 5 - i);
      pulse(100, 6);
      tick(12);
      pulse(0, 0);
      check("C_valid", 128'(bus.slot_valid), 128'(4'b1111));
      check("C_ovf",   128'(bus.overflow),   128'(1));
      for (int i = 0; i < SLOTS; i++) begin
`ifdef ALIEN_SCHED_DEPTH_SORT_EN
         check("C_r", 128'(bus.slot_data[i]._r), 128'(i));
`else
         check("C_r", 128'(bus.slot_data[i]._r), 128'(5 - i));
`endif
      end

      // Second line_start 5 cycles into an 8-entry scan: partial publish, restart.
      for (int i = 0; i < MAX_ALIENS; i++) tbl[i] = mk(i, 100, 0);
      pulse(100, 8);
      tick(4);
      pulse(100, 8);
      check("D_late",  128'(bus.late),       128'(1));
      check("D_valid", 128'(bus.slot_valid), 128'(4'b0011));
      check("D_ovf",   128'(bus.overflow),   128'(0));
      check("D_addr",  128'(bus.tbl_addr),   128'(0));
      tick(17);
      pulse(0, 0);
      check("D2_late",  128'(bus.late),       128'(0));
      check("D2_valid", 128'(bus.slot_valid), 128'(4'b1111));
      check("D2_ovf",   128'(bus.overflow),   128'(1));

      // Reset coincident with line_start wins.
      pulse(100, 8);
      tick(3);
      rst_n           = 1'b0;
      bus.line_start  = 1'b1;
      bus.alien_count = CW'(8);
      tick(1);
      check("E_valid", 128'(bus.slot_valid), 128'(0));
      check("E_data",  128'(bus.slot_data),  128'(0));
      check("E_ovf",   128'(bus.overflow),   128'(0));
      check("E_late",  128'(bus.late),       128'(0));
      check("E_addr",  128'(bus.tbl_addr),   128'(0));
      rst_n          = 1'b1;
      bus.line_start = 1'b0;
      tick(2);
      pulse(0, 0);
      check("E_idle_late",  128'(bus.late),       128'(0));
      check("E_idle_valid", 128'(bus.slot_valid), 128'(0));

      // Empty table: scan is done one cycle after line_start.
      for (int i = 0; i < 6; i++) tbl[i] = mk(i, 100, 1);
      pulse(100, 6);
      tick(12);
      pulse(0, 0);
      check("F_ovf_pre", 128'(bus.overflow), 128'(1));
      pulse(0, 0);
      check("F_late",  128'(bus.late),       128'(0));
      check("F_valid", 128'(bus.slot_valid), 128'(0));
      check("F_ovf",   128'(bus.overflow),   128'(0));

      tick(2);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
